// File: rtl/round_key_ctrl_pkg.sv
// Shared constants and types for the round-key controller slice.
package round_key_ctrl_pkg;

  localparam int KEY_W      = 128;  // key / round-key width
  localparam int DEPTH      = 16;   // register-file entries
  localparam int ADDR_W     = 4;    // round-address width
  localparam int MAX_ROUNDS = 14;   // largest accepted rounds_total
  localparam int WDOG_SLACK = 4;    // extra cycles before expansion counts as hung
  localparam int CNT_W      = 5;    // holds rounds+1+slack (max 19)

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // no key
    WAIT_IDLE = 2'd1,  // key captured, waiting for the cipher to go idle
    EXPAND    = 2'd2,  // expander running, schedule being written
    READY     = 2'd3   // complete schedule stored
  } state_e;

  // A rounds value is usable when it is 1..MAX_ROUNDS.
  function automatic logic rounds_legal(input logic [ADDR_W-1:0] rounds);
    return (rounds != '0) && (rounds <= ADDR_W'(MAX_ROUNDS));
  endfunction

endpackage

// File: rtl/round_key_ctrl_if.sv
// Host / expander / cipher-read signal bundle of the round-key controller.
// master = surrounding logic, slave = round_key_ctrl.
interface round_key_ctrl_if;

  // host key load
  logic                                 key_load_valid;
  logic                                 key_load_ready;
  logic [round_key_ctrl_pkg::KEY_W-1:0] key_in;
  logic [3:0]                           rounds_in;
  logic                                 cipher_busy;
  // expander
  logic                                 exp_en;
  logic [round_key_ctrl_pkg::KEY_W-1:0] exp_key;
  logic [3:0]                           exp_rounds;
  logic [3:0]                           exp_addr;
  logic [round_key_ctrl_pkg::KEY_W-1:0] exp_data;
  logic                                 exp_we;
  logic                                 exp_done;
  // cipher read port
  logic                                 rk_rd_en;
  logic [3:0]                           rk_rd_addr;
  logic [round_key_ctrl_pkg::KEY_W-1:0] rk_rd_data;
  logic                                 rk_rd_valid;
  // status
  logic                                 key_valid;
  logic                                 err;

  modport master (
    output key_load_valid, key_in, rounds_in, cipher_busy,
           exp_addr, exp_data, exp_we, exp_done, rk_rd_en, rk_rd_addr,
    input  key_load_ready, exp_en, exp_key, exp_rounds,
           rk_rd_data, rk_rd_valid, key_valid, err
  );

  modport slave (
    input  key_load_valid, key_in, rounds_in, cipher_busy,
           exp_addr, exp_data, exp_we, exp_done, rk_rd_en, rk_rd_addr,
    output key_load_ready, exp_en, exp_key, exp_rounds,
           rk_rd_data, rk_rd_valid, key_valid, err
  );

endinterface

// File: rtl/round_key_ctrl_rk_regfile.sv
// DEPTH x KEY_W round-key store: one write port, one registered read port.
// clr wipes every entry in one cycle (driven only when ROUND_KEY_CTRL_ZEROIZE_EN
// is defined in the parent). The read register always resets to 0.
module round_key_ctrl_rk_regfile
  import round_key_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rdata
);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [KEY_W-1:0] rdata_q, rdata_d;

  // Storage write; clear has priority over a write in the same cycle.
  // NOTE: the array has no reset branch so it maps onto plain storage; only clr wipes it.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read data: new entry on a read, otherwise hold.
  // NOTE: assigning the default first keeps this block purely combinational.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Read data register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/round_key_ctrl.sv
// Round-key controller: captures host keys, defers the load until the cipher
// is idle, launches the expander, checks its write count and timing, and
// serves cipher reads while a complete schedule is stored.
// Optional: ROUND_KEY_CTRL_ZEROIZE_EN clears the register file on reset and
// on every expansion start.
module round_key_ctrl
  import round_key_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  round_key_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   exp_key_q, exp_key_d;
  logic [3:0]         exp_rounds_q, exp_rounds_d;
  logic               exp_en_q, exp_en_d;
  logic               key_valid_q, key_valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               rd_valid_q, rd_valid_d;

  logic               capture;
  logic               enter_expand;
  logic               wr_fire, wr_ok, rd_fire;
  logic [CNT_W-1:0]   sched_len, wr_cnt_inc, wdog_inc;
  logic               rf_clr;

  // Handshake and datapath qualifiers.
  assign capture    = (state_q == IDLE || state_q == READY) && bus.key_load_valid && !reset;
  assign sched_len  = {1'b0, exp_rounds_q} + CNT_W'(1);
  assign wr_fire    = (state_q == EXPAND) && bus.exp_we;
  assign wr_ok      = wr_fire && (bus.exp_addr <= exp_rounds_q);
  assign rd_fire    = bus.rk_rd_en && key_valid_q;
  assign wr_cnt_inc = wr_cnt_q + CNT_W'(wr_fire);
  assign wdog_inc   = wdog_q + CNT_W'(1);

  // Next-state, counters and status.
  always_comb begin
    state_d      = state_q;
    exp_key_d    = exp_key_q;
    exp_rounds_d = exp_rounds_q;
    exp_en_d     = 1'b0;
    key_valid_d  = key_valid_q;
    err_d        = err_q;
    wr_cnt_d     = wr_cnt_q;
    wdog_d       = wdog_q;
    enter_expand = 1'b0;

    case (state_q)
      IDLE, READY: begin
        if (capture) begin
          if (rounds_legal(bus.rounds_in)) begin
            exp_key_d    = bus.key_in;
            exp_rounds_d = bus.rounds_in;
            if (bus.cipher_busy) state_d = WAIT_IDLE;
            else                 enter_expand = 1'b1;
          end else begin
            // Rejected key: old schedule and its rounds stay in force.
            err_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (!bus.cipher_busy) enter_expand = 1'b1;
      end
      EXPAND: begin
        wdog_d   = wdog_inc;
        wr_cnt_d = wr_cnt_inc;
        if (wr_fire && !wr_ok) err_d = 1'b1;
        if (bus.exp_done) begin
          if (wr_cnt_inc == sched_len) begin
            state_d     = READY;
            key_valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (wdog_inc >= sched_len + CNT_W'(WDOG_SLACK)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Expansion start: one exp_en pulse, schedule invalidated, counters cleared.
    if (enter_expand) begin
      state_d     = EXPAND;
      exp_en_d    = 1'b1;
      key_valid_d = 1'b0;
      wr_cnt_d    = '0;
      wdog_d      = '0;
    end

    rd_valid_d = rd_fire;
    if (rd_fire && (bus.rk_rd_addr > exp_rounds_q)) err_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_key_q    <= '0;
      exp_rounds_q <= '0;
      exp_en_q     <= 1'b0;
      key_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      wr_cnt_q     <= '0;
      wdog_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_key_q    <= exp_key_d;
      exp_rounds_q <= exp_rounds_d;
      exp_en_q     <= exp_en_d;
      key_valid_q  <= key_valid_d;
      err_q        <= err_d;
      wr_cnt_q     <= wr_cnt_d;
      wdog_q       <= wdog_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
  assign rf_clr = reset | enter_expand;
`else
  assign rf_clr = 1'b0;
`endif

  round_key_ctrl_rk_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .clr   (rf_clr),
    .we    (wr_ok),
    .waddr (bus.exp_addr),
    .wdata (bus.exp_data),
    .re    (rd_fire),
    .raddr (bus.rk_rd_addr),
    .rdata (bus.rk_rd_data)
  );

  assign bus.key_load_ready = capture;
  assign bus.exp_en         = exp_en_q;
  assign bus.exp_key        = exp_key_q;
  assign bus.exp_rounds     = exp_rounds_q;
  assign bus.rk_rd_valid    = rd_valid_q;
  assign bus.key_valid      = key_valid_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_round_key_ctrl.sv
// Bench for round_key_ctrl with an AES-128 key-expansion model acting as the
// expander and a read scoreboard.
module tb_round_key_ctrl;

  logic clk = 1'b0;
  logic reset;
  round_key_ctrl_if bus ();

  round_key_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] model_rk [15];
  logic [127:0] ref_mem  [16];
  logic [127:0] sb_q [$];

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3     = 128'hdeadbeef00112233445566778899aabb;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 key expansion model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 60; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroize_ref();
`ifdef ROUND_KEY_CTRL_ZEROIZE_EN
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.key_load_valid = 1'b0;
    bus.key_in         = '0;
    bus.rounds_in      = '0;
    bus.cipher_busy    = 1'b0;
    bus.exp_addr       = '0;
    bus.exp_data       = '0;
    bus.exp_we         = 1'b0;
    bus.exp_done       = 1'b0;
    bus.rk_rd_en       = 1'b0;
    bus.rk_rd_addr     = '0;
    step();
    step();
    reset = 1'b0;
    zeroize_ref();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key_load_ready"}, bus.key_load_ready, 0);
    check({tag, "_exp_en"},         bus.exp_en, 0);
    check({tag, "_exp_key"},        bus.exp_key, 0);
    check({tag, "_exp_rounds"},     bus.exp_rounds, 0);
    check({tag, "_rk_rd_data"},     bus.rk_rd_data, 0);
    check({tag, "_rk_rd_valid"},    bus.rk_rd_valid, 0);
    check({tag, "_key_valid"},      bus.key_valid, 0);
    check({tag, "_err"},            bus.err, 0);
  endtask

  // Offer a key for one cycle; ready must be high while it is offered.
  task automatic load_key(input logic [127:0] k, input logic [3:0] r);
    bus.key_load_valid = 1'b1;
    bus.key_in         = k;
    bus.rounds_in      = r;
    #1;
    check("key_load_ready", bus.key_load_ready, 1);
    step();
    bus.key_load_valid = 1'b0;
    #1;
    check("key_load_ready_drop", bus.key_load_ready, 0);
  endtask

  // Probe that the controller accepts keys (IDLE/READY) without launching one.
  task automatic idle_probe(input string tag);
    bus.key_load_valid = 1'b1;
    #1;
    check(tag, bus.key_load_ready, 1);
    bus.key_load_valid = 1'b0;
    #1;
  endtask

  // Expander model: n writes of the modelled schedule, optional done on the last.
  task automatic expand_model(input int n, input bit give_done);
    for (int i = 0; i < n; i++) begin
      bus.exp_we   = 1'b1;
      bus.exp_addr = i[3:0];
      bus.exp_data = model_rk[i];
      bus.exp_done = give_done && (i == n - 1);
      ref_mem[i]   = model_rk[i];
      step();
    end
    bus.exp_we   = 1'b0;
    bus.exp_done = 1'b0;
  endtask

  // Issue one read; push the expected data when it should be served.
  task automatic do_read(input logic [3:0] addr, input bit expect_ok);
    bus.rk_rd_en   = 1'b1;
    bus.rk_rd_addr = addr;
    if (expect_ok) sb_q.push_back(ref_mem[addr]);
    step();
    bus.rk_rd_en = 1'b0;
    check("rd_valid", bus.rk_rd_valid, 128'(expect_ok));
  endtask

  // Read-data scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.rk_rd_valid === 1'b1) begin
      if (sb_q.size() == 0) check("rd_unexpected", 128'(bus.rk_rd_valid), 0);
      else                  check("rd_data", bus.rk_rd_data, sb_q.pop_front());
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    do_reset();
    check_reset_vals("rst");

    // 1: basic load of the FIPS-197 key, 10 rounds.
    build_schedule(K1);
    load_key(K1, 4'd10);
    check("t1_exp_en", bus.exp_en, 1);
    check("t1_exp_key", bus.exp_key, K1);
    check("t1_exp_rounds", bus.exp_rounds, 10);
    zeroize_ref();
    step();
    check("t1_exp_en_once", bus.exp_en, 0);
    expand_model(11, 1'b1);
    check("t1_key_valid", bus.key_valid, 1);
    check("t1_err", bus.err, 0);
    do_read(4'd10, 1'b1);
    check("t1_rd10_const", bus.rk_rd_data, K1_R10);

    // 2: deferred load while the cipher is busy; 5: read gating in EXPAND.
    build_schedule(K2);
    bus.cipher_busy = 1'b1;
    load_key(K2, 4'd10);
    for (int c = 0; c < 20; c++) begin
      do_read(4'd0, 1'b1);
      check("t2_no_exp_en", bus.exp_en, 0);
    end
    check("t2_old_valid", bus.key_valid, 1);
    bus.cipher_busy = 1'b0;
    step();
    check("t2_exp_en", bus.exp_en, 1);
    check("t2_key_valid_drop", bus.key_valid, 0);
    zeroize_ref();
    do_read(4'd3, 1'b0);
    check("t2_exp_en_once", bus.exp_en, 0);
    expand_model(11, 1'b1);
    check("t2_key_valid", bus.key_valid, 1);
    check("t2_err", bus.err, 0);
    do_read(4'd0, 1'b1);
    check("t2_rd0_k2", bus.rk_rd_data, K2);

    // 3: illegal rounds (15) in READY keeps state and schedule.
    load_key(K3, 4'd15);
    check("t3_err", bus.err, 1);
    check("t3_key_valid", bus.key_valid, 1);
    for (int c = 0; c < 3; c++) begin
      check("t3_no_exp_en", bus.exp_en, 0);
      step();
    end
    do_read(4'd0, 1'b1);
    idle_probe("t3_still_ready");

    // 3b: rounds 0 in IDLE is rejected too.
    do_reset();
    load_key(K3, 4'd0);
    check("t3b_err", bus.err, 1);
    check("t3b_no_exp_en", bus.exp_en, 0);
    check("t3b_key_valid", bus.key_valid, 0);
    idle_probe("t3b_still_idle");

    // 4a: expander gives only 9 writes before done.
    do_reset();
    build_schedule(K1);
    load_key(K1, 4'd10);
    check("t4a_exp_en", bus.exp_en, 1);
    zeroize_ref();
    step();
    expand_model(9, 1'b1);
    check("t4a_err", bus.err, 1);
    check("t4a_key_valid", bus.key_valid, 0);
    idle_probe("t4a_idle");
    do_read(4'd0, 1'b0);

    // 4b: expander never signals done; watchdog fires 15 cycles after exp_en.
    do_reset();
    load_key(K1, 4'd10);
    check("t4b_exp_en", bus.exp_en, 1);
    zeroize_ref();
    for (int c = 0; c < 14; c++) step();
    check("t4b_err_early", bus.err, 0);
    step();
    check("t4b_err_at_15", bus.err, 1);
    check("t4b_key_valid", bus.key_valid, 0);
    idle_probe("t4b_idle");

    // 6: reset after write 5 abandons the schedule; a full reload then works.
    do_reset();
    load_key(K1, 4'd10);
    zeroize_ref();
    step();
    expand_model(5, 1'b0);
    do_reset();
    check_reset_vals("t6_rst");
    load_key(K1, 4'd10);
    check("t6_exp_en", bus.exp_en, 1);
    zeroize_ref();
    step();
    expand_model(11, 1'b1);
    check("t6_key_valid", bus.key_valid, 1);
    do_read(4'd5, 1'b1);

    // 6b: 1-round load; addr 3 is out of range (err) and holds stale or zeroized data.
    do_reset();
    load_key(K1, 4'd1);
    zeroize_ref();
    step();
    expand_model(2, 1'b1);
    check("t6b_key_valid", bus.key_valid, 1);
    check("t6b_err_before", bus.err, 0);
    do_read(4'd3, 1'b1);
    check("t6b_err_range", bus.err, 1);

    step();
    step();
    check("sb_empty", 128'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
